// File: rtl/stream_packet_mux_pkg.sv
// Shared types for the stream arbiter: lock FSM states and the default-width output beat.
// No logic, no latency, no backpressure; types only.
package stream_arb_pkg;
    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_QOS_WIDTH    = 4;
    localparam int DEF_STREAM_COUNT = 2;
    localparam int DEF_ID_WIDTH     = $clog2(DEF_STREAM_COUNT);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic [DEF_QOS_WIDTH-1:0]  qos;
        logic                      last;
        logic [DEF_ID_WIDTH-1:0]   id;
    } beat_t;
endpackage

// File: rtl/stream_packet_mux_if.sv
// Bundle of per-stream inputs, winner id and the arbiter master port.
// slave = the mux itself; master = whoever drives the streams and sinks the output.
interface stream_packet_mux_if #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_QOS_WIDTH  = 4,
    parameter int STREAM_COUNT = 2,
    parameter int T_ID_WIDTH   = $clog2(STREAM_COUNT)
);
    logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i;
    logic [STREAM_COUNT-1:0][T_QOS_WIDTH-1:0]  s_qos_i;
    logic [STREAM_COUNT-1:0]                   s_last_i;
    logic [STREAM_COUNT-1:0]                   s_valid_i;
    logic [STREAM_COUNT-1:0]                   s_ready_o;
    logic [T_ID_WIDTH-1:0]                     sel_id_i;
    logic [T_DATA_WIDTH-1:0]                   m_data_o;
    logic [T_QOS_WIDTH-1:0]                    m_qos_o;
    logic [T_ID_WIDTH-1:0]                     m_id_o;
    logic                                      m_last_o;
    logic                                      m_valid_o;
    logic                                      m_ready_i;

    modport slave (
        input  s_data_i, s_qos_i, s_last_i, s_valid_i, sel_id_i, m_ready_i,
        output s_ready_o, m_data_o, m_qos_o, m_id_o, m_last_o, m_valid_o
    );

    modport master (
        output s_data_i, s_qos_i, s_last_i, s_valid_i, sel_id_i, m_ready_i,
        input  s_ready_o, m_data_o, m_qos_o, m_id_o, m_last_o, m_valid_o
    );
endinterface

// File: rtl/stream_packet_mux_out_reg.sv
// One-entry valid/ready pipeline register; 1 cycle in-to-out, full rate with no bubble.
// in_ready = !out_valid || out_ready; contents held stable while stalled.
module stream_out_reg #(
    parameter type beat_t = stream_arb_pkg::beat_t
) (
    input  logic  clk,
    input  logic  rst,
    input  beat_t in_beat,
    input  logic  in_valid,
    output logic  in_ready,
    output beat_t out_beat,
    output logic  out_valid,
    input  logic  out_ready
);
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_beat  <= '0;
        end else if (in_valid && in_ready) begin
            out_beat  <= in_beat;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/stream_packet_mux.sv
// Packet-locked stream mux: grants the selected stream for a whole packet; valid->m_valid 2 cycles min.
// Backpressure: only the granted stream sees ready, gated by the output register's free slot.
module stream_packet_mux
    import stream_arb_pkg::*;
#(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_QOS_WIDTH  = 4,
    parameter int STREAM_COUNT = 2,
    parameter int T_ID_WIDTH   = $clog2(STREAM_COUNT)
) (
    input logic               clk,
    input logic               rst,
    stream_packet_mux_if.slave bus
);
    typedef struct packed {
        logic [T_DATA_WIDTH-1:0] data;
        logic [T_QOS_WIDTH-1:0]  qos;
        logic                    last;
        logic [T_ID_WIDTH-1:0]   id;
    } mux_beat_t;

    state_t                state;
    logic [T_ID_WIDTH-1:0] grant_id;
    logic                  sel_valid;
    logic                  in_valid;
    logic                  acc_ready;
    logic                  accept;
    mux_beat_t             in_beat;
    mux_beat_t             out_beat;

    // The selector reports id 0 even when nothing is valid, so qualify it here.
    always_comb begin
        sel_valid = (int'(bus.sel_id_i) < STREAM_COUNT) && bus.s_valid_i[bus.sel_id_i];
        in_valid  = (state == LOCKED) && bus.s_valid_i[grant_id];
        accept    = in_valid && acc_ready;
        in_beat   = '{data: bus.s_data_i[grant_id],
                      qos:  bus.s_qos_i[grant_id],
                      last: bus.s_last_i[grant_id],
                      id:   grant_id};
    end

    always_comb begin
        bus.s_ready_o = '0;
        if (state == LOCKED) bus.s_ready_o[grant_id] = acc_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        grant_id <= bus.sel_id_i;
                        state    <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (accept && in_beat.last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    stream_out_reg #(.beat_t(mux_beat_t)) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .in_beat   (in_beat),
        .in_valid  (in_valid),
        .in_ready  (acc_ready),
        .out_beat  (out_beat),
        .out_valid (bus.m_valid_o),
        .out_ready (bus.m_ready_i)
    );

    assign bus.m_data_o = out_beat.data;
    assign bus.m_qos_o  = out_beat.qos;
    assign bus.m_last_o = out_beat.last;
    assign bus.m_id_o   = out_beat.id;
endmodule

// File: tb/tb_stream_packet_mux.sv
// Bench for stream_packet_mux: directed cycle table, hand sequences and random traffic
// all checked every cycle against a packet-level reference model.
module tb_stream_packet_mux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_packet_mux_if #(.T_DATA_WIDTH(8), .T_QOS_WIDTH(4), .STREAM_COUNT(2)) bus ();

    stream_packet_mux #(.T_DATA_WIDTH(8), .T_QOS_WIDTH(4), .STREAM_COUNT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic [3:0] qos;
        logic       last;
        logic       id;
    } beat_s;

    typedef struct {
        logic [1:0] valid;
        logic [1:0] last;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       sel;
        logic       mrdy;
        logic       e_mv;
        logic [7:0] e_md;
        logic       e_ml;
        logic       e_id;
        logic [1:0] e_sr;
    } vec_t;

    int errors = 0;
    int checks = 0;

    logic [1:0] d_valid, d_last, gap;
    logic [7:0] d_data[2];
    logic [3:0] d_qos[2];
    logic       d_sel, d_mrdy;
    bit         use_q;
    beat_s      src_q[2][$];

    // Reference: owner of the lock (-1 none) and the beats waiting on the master port.
    int         owner = -1;
    beat_s      mq[$];
    logic [1:0] exp_sr, dut_sr;
    vec_t       tbl[14];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(int s, int n, logic [7:0] base, logic [3:0] q);
        beat_s b;
        for (int i = 0; i < n; i++) begin
            b.data = base + 8'(i);
            b.qos  = q;
            b.last = (i == n - 1);
            b.id   = s[0];
            src_q[s].push_back(b);
        end
    endtask

    task automatic pre();
        if (use_q) begin
            for (int s = 0; s < 2; s++) begin
                d_valid[s] = (src_q[s].size() > 0) && !gap[s];
                if (src_q[s].size() > 0) begin
                    d_data[s] = src_q[s][0].data;
                    d_qos[s]  = src_q[s][0].qos;
                    d_last[s] = src_q[s][0].last;
                end else begin
                    d_data[s] = '0;
                    d_qos[s]  = '0;
                    d_last[s] = 1'b0;
                end
            end
        end
        bus.s_valid_i = d_valid;
        bus.s_last_i  = d_last;
        bus.s_data_i  = {d_data[1], d_data[0]};
        bus.s_qos_i   = {d_qos[1], d_qos[0]};
        bus.sel_id_i  = d_sel;
        bus.m_ready_i = d_mrdy;
        #1;
        exp_sr = (owner >= 0 && (mq.size() == 0 || d_mrdy)) ? 2'(1 << owner) : 2'b00;
        chk("s_ready", 32'(bus.s_ready_o), 32'(exp_sr));
        chk("m_valid", 32'(bus.m_valid_o), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("m_data", 32'(bus.m_data_o), 32'(mq[0].data));
            chk("m_qos",  32'(bus.m_qos_o),  32'(mq[0].qos));
            chk("m_last", 32'(bus.m_last_o), 32'(mq[0].last));
            chk("m_id",   32'(bus.m_id_o),   32'(mq[0].id));
        end
        dut_sr = bus.s_ready_o;
    endtask

    task automatic post();
        beat_s b;
        @(posedge clk);
        if (rst) begin
            owner = -1;
            mq.delete();
        end else begin
            if (mq.size() != 0 && d_mrdy) void'(mq.pop_front());
            if (owner < 0) begin
                if (d_valid[d_sel]) owner = int'(d_sel);
            end else if (d_valid[owner] && exp_sr[owner]) begin
                b.data = d_data[owner];
                b.qos  = d_qos[owner];
                b.last = d_last[owner];
                b.id   = owner[0];
                mq.push_back(b);
                if (d_last[owner]) owner = -1;
            end
            if (use_q)
                for (int s = 0; s < 2; s++)
                    if (dut_sr[s] && d_valid[s]) void'(src_q[s].pop_front());
        end
        @(negedge clk);
    endtask

    task automatic tick();
        pre();
        post();
    endtask

    task automatic drain(string name);
        for (int k = 0; k < 60 && (src_q[0].size() + src_q[1].size() + mq.size()) != 0; k++)
            tick();
        chk({name, "_drained"}, 32'(src_q[0].size() + src_q[1].size() + mq.size()), 32'd0);
    endtask

    initial begin
        d_valid = '0; d_last = '0; gap = '0; d_sel = 1'b0; d_mrdy = 1'b1; use_q = 1'b0;
        d_data[0] = '0; d_data[1] = '0; d_qos[0] = 4'h2; d_qos[1] = 4'h9;
        bus.s_valid_i = '0; bus.s_last_i = '0; bus.s_data_i = '0; bus.s_qos_i = '0;
        bus.sel_id_i = '0; bus.m_ready_i = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_m_valid", 32'(bus.m_valid_o), 0);
        chk("rst_m_data",  32'(bus.m_data_o),  0);
        chk("rst_m_qos",   32'(bus.m_qos_o),   0);
        chk("rst_m_id",    32'(bus.m_id_o),    0);
        chk("rst_m_last",  32'(bus.m_last_o),  0);
        chk("rst_s_ready", 32'(bus.s_ready_o), 0);

        // Lock/latency on stream 1, idle guard, then stream 0 packet not preempted by stream 1.
        tbl[0]  = '{2'b10, 2'b00, 8'h00, 8'hA1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00};
        tbl[1]  = '{2'b10, 2'b00, 8'h00, 8'hA1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b10};
        tbl[2]  = '{2'b10, 2'b00, 8'h00, 8'hA2, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 2'b10};
        tbl[3]  = '{2'b10, 2'b10, 8'h00, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b0, 1'b1, 2'b10};
        tbl[4]  = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b1, 2'b00};
        tbl[5]  = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00};
        tbl[6]  = '{2'b01, 2'b00, 8'hB1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00};
        tbl[7]  = '{2'b01, 2'b00, 8'hB1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01};
        tbl[8]  = '{2'b11, 2'b10, 8'hB2, 8'hC1, 1'b1, 1'b1, 1'b1, 8'hB1, 1'b0, 1'b0, 2'b01};
        tbl[9]  = '{2'b11, 2'b11, 8'hB3, 8'hC1, 1'b1, 1'b1, 1'b1, 8'hB2, 1'b0, 1'b0, 2'b01};
        tbl[10] = '{2'b10, 2'b10, 8'h00, 8'hC1, 1'b1, 1'b1, 1'b1, 8'hB3, 1'b1, 1'b0, 2'b00};
        tbl[11] = '{2'b10, 2'b10, 8'h00, 8'hC1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b10};
        tbl[12] = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'hC1, 1'b1, 1'b1, 2'b00};
        tbl[13] = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00};

        for (int i = 0; i < 14; i++) begin
            d_valid = tbl[i].valid; d_last = tbl[i].last;
            d_data[0] = tbl[i].d0; d_data[1] = tbl[i].d1;
            d_sel = tbl[i].sel; d_mrdy = tbl[i].mrdy;
            pre();
            chk($sformatf("tbl%0d_s_ready", i), 32'(bus.s_ready_o), 32'(tbl[i].e_sr));
            chk($sformatf("tbl%0d_m_valid", i), 32'(bus.m_valid_o), 32'(tbl[i].e_mv));
            if (tbl[i].e_mv) begin
                chk($sformatf("tbl%0d_m_data", i), 32'(bus.m_data_o), 32'(tbl[i].e_md));
                chk($sformatf("tbl%0d_m_last", i), 32'(bus.m_last_o), 32'(tbl[i].e_ml));
                chk($sformatf("tbl%0d_m_id", i),   32'(bus.m_id_o),   32'(tbl[i].e_id));
            end
            post();
        end

        // Backpressure: hold D1 on the master port for 4 cycles while stream 1 also waits.
        use_q = 1'b1; d_sel = 1'b0; d_mrdy = 1'b1;
        push_pkt(0, 4, 8'hD1, 4'h3);
        push_pkt(1, 2, 8'h51, 4'hF);
        tick(); tick();
        d_mrdy = 1'b0;
        d_sel  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pre();
            chk("bp_hold_data",  32'(bus.m_data_o),  32'hD1);
            chk("bp_hold_valid", 32'(bus.m_valid_o), 1);
            chk("bp_s_ready",    32'(bus.s_ready_o), 0);
            post();
        end
        d_mrdy = 1'b1;
        drain("bp");

        // Valid gap on the granted stream while the other stream is valid and selected.
        d_sel = 1'b1;
        push_pkt(1, 4, 8'hE1, 4'h1);
        push_pkt(0, 1, 8'hF1, 4'hE);
        tick(); tick(); tick();
        gap = 2'b10; d_sel = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pre();
            chk("gap_s_ready_other", 32'(bus.s_ready_o[0]), 0);
            post();
        end
        gap = 2'b00;
        drain("gap");

        // Reset after 2 of 4 beats, then a fresh packet on stream 1.
        d_sel = 1'b0;
        push_pkt(0, 4, 8'h61, 4'h5);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        src_q[0].delete();
        #1;
        chk("rstmid_m_valid", 32'(bus.m_valid_o), 0);
        chk("rstmid_s_ready", 32'(bus.s_ready_o), 0);
        d_sel = 1'b1;
        push_pkt(1, 2, 8'h71, 4'h7);
        drain("rstmid");

        // Random traffic against the reference model.
        for (int c = 0; c < 1500; c++) begin
            for (int s = 0; s < 2; s++)
                if (src_q[s].size() < 6 && $urandom_range(0, 3) == 0)
                    push_pkt(s, $urandom_range(1, 4), 8'($urandom), 4'($urandom));
            d_sel  = 1'($urandom);
            d_mrdy = ($urandom_range(0, 9) < 7);
            gap    = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
            tick();
        end
        gap = 2'b00; d_mrdy = 1'b1;
        for (int k = 0; k < 60 && (src_q[0].size() + src_q[1].size()) != 0; k++) begin
            d_sel = (src_q[0].size() != 0) ? 1'b0 : 1'b1;
            tick();
        end
        drain("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end
endmodule
